// File: rtl/fdiv_sched.sv
// Sequencer/arbiter for the shared iterative FP divider: grants one of two issue
// slots, times the fixed divider latency, then offers the result via valid/ready.
// Build option: define FDIV_SCHED_RR_EN for round-robin arbitration (else fixed priority, slot 0 wins).
module fdiv_sched #(
  parameter int unsigned LAT  = 16,
  parameter int unsigned TAGW = 5
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            req0,
  input  logic            req1,
  input  logic [TAGW-1:0] tag0,
  input  logic [TAGW-1:0] tag1,
  input  logic            flush,
  input  logic            res_ready,
  output logic            gnt0,
  output logic            gnt1,
  output logic            stall0,
  output logic            stall1,
  output logic            dv_start,
  output logic            dv_sel,
  output logic            busy,
  output logic [4:0]      cnt,
  output logic            res_valid,
  output logic [TAGW-1:0] res_tag,
  output logic            res_src
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [4:0] LAST = 5'(LAT - 1);

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic            src_q, src_d;
  logic            grant_ok, pick1, any_gnt;
`ifdef FDIV_SCHED_RR_EN
  logic            ptr_q, ptr_d;
`endif

  // Arbiter. clrn gates the grant so gnt* read 0 while reset is asserted.
  always_comb begin
    grant_ok = clrn && !flush && ((state_q == IDLE) || (state_q == DONE && res_ready));
`ifdef FDIV_SCHED_RR_EN
    pick1    = req1 && (!req0 || ptr_q);
`else
    pick1    = req1 && !req0;
`endif
    any_gnt  = grant_ok && (req0 || req1);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      tag_q   <= '0;
      src_q   <= 1'b0;
`ifdef FDIV_SCHED_RR_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      src_q   <= src_d;
`ifdef FDIV_SCHED_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    src_d   = src_q;
`ifdef FDIV_SCHED_RR_EN
    ptr_d   = ptr_q;
`endif
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (any_gnt) begin
      // Covers both IDLE issue and the zero-bubble DONE handshake.
      state_d = RUN;
      cnt_d   = 5'd1;
      valid_d = 1'b0;
      tag_d   = pick1 ? tag1 : tag0;
      src_d   = pick1;
`ifdef FDIV_SCHED_RR_EN
      ptr_d   = !pick1;
`endif
    end else begin
      unique case (state_q)
        RUN: begin
          if (cnt_q == LAST) begin
            state_d = DONE;
            cnt_d   = '0;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt0      = any_gnt && !pick1;
    gnt1      = any_gnt && pick1;
    stall0    = req0 && !gnt0;
    stall1    = req1 && !gnt1;
    dv_start  = gnt0 || gnt1;
    dv_sel    = src_q;
    busy      = (state_q != IDLE);
    cnt       = cnt_q;
    res_valid = valid_q;
    res_tag   = tag_q;
    res_src   = src_q;
  end

endmodule

// File: tb/tb_fdiv_sched.sv
// Bench for fdiv_sched: timestamp-based reference model checks control outputs each
// cycle; a scoreboard queue of expected {tag,src} is drained by an independent monitor.
module tb_fdiv_sched;
  localparam int unsigned LAT  = 16;
  localparam int unsigned TAGW = 5;

  logic            clk = 1'b0;
  logic            clrn = 1'b0;
  logic            req0 = 1'b0, req1 = 1'b0;
  logic [TAGW-1:0] tag0 = '0, tag1 = '0;
  logic            flush = 1'b0, res_ready = 1'b0;
  logic            gnt0, gnt1, stall0, stall1, dv_start, dv_sel, busy, res_valid, res_src;
  logic [4:0]      cnt;
  logic [TAGW-1:0] res_tag;

  always #5 clk = ~clk;

  fdiv_sched #(.LAT(LAT), .TAGW(TAGW)) dut (
    .clk(clk), .clrn(clrn), .req0(req0), .req1(req1), .tag0(tag0), .tag1(tag1),
    .flush(flush), .res_ready(res_ready), .gnt0(gnt0), .gnt1(gnt1),
    .stall0(stall0), .stall1(stall1), .dv_start(dv_start), .dv_sel(dv_sel),
    .busy(busy), .cnt(cnt), .res_valid(res_valid), .res_tag(res_tag), .res_src(res_src)
  );

  typedef struct {
    logic [TAGW-1:0] tag;
    logic            src;
  } res_t;
  res_t sb[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  // Model: an op is "running" since grant cycle m_gcyc; a result is "pending" until consumed.
  bit m_run = 0, m_pend = 0, m_owner = 0, m_prio = 0;
  int m_gcyc = 0;
  bit g0_last = 0, g1_last = 0, s_start = 0;
  int s_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_owner = 0; m_prio = 0;
    sb.delete();
  endtask

  task automatic chk_reset_vals();
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_stall0", 32'(stall0), 32'(req0));
    chk("rst_stall1", 32'(stall1), 32'(req1));
    chk("rst_dv_start", 32'(dv_start), 0);
    chk("rst_dv_sel", 32'(dv_sel), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_tag", 32'(res_tag), 0);
    chk("rst_res_src", 32'(res_src), 0);
  endtask

  task automatic check_and_update();
    bit opp, w1, g;
    int age;
    g0_last = 0; g1_last = 0;
    s_start = dv_start; s_cyc = cyc;
    if (!clrn) begin
      chk_reset_vals();
      model_reset();
      return;
    end
    age = cyc - m_gcyc;
    opp = !flush && ((!m_run && !m_pend) || (m_pend && res_ready));
`ifdef FDIV_SCHED_RR_EN
    w1 = req1 && (!req0 || m_prio);
`else
    w1 = req1 && !req0;
`endif
    g = opp && (req0 || req1);
    chk("gnt0", 32'(gnt0), 32'(g && !w1));
    chk("gnt1", 32'(gnt1), 32'(g && w1));
    chk("dv_start", 32'(dv_start), 32'(g));
    chk("stall0", 32'(stall0), 32'(req0 && !(g && !w1)));
    chk("stall1", 32'(stall1), 32'(req1 && !(g && w1)));
    chk("busy", 32'(busy), 32'(m_run || m_pend));
    chk("cnt", 32'(cnt), m_run ? 32'(age) : 32'd0);
    chk("res_valid", 32'(res_valid), 32'(m_pend));
    chk("dv_sel", 32'(dv_sel), 32'(m_owner));
    if (flush) begin
      m_run = 0; m_pend = 0;
      sb.delete();
    end else if (g) begin
      sb.push_back('{tag: (w1 ? tag1 : tag0), src: w1});
      m_run = 1; m_pend = 0; m_gcyc = cyc; m_owner = w1; m_prio = !w1;
      g0_last = !w1; g1_last = w1;
    end else if (m_pend && res_ready) begin
      m_pend = 0;
    end else if (m_run && age == int'(LAT) - 1) begin
      m_run = 0; m_pend = 1;
    end
  endtask

  // Scoreboard monitor: independent of stimulus; pops on every accepted result.
  always @(negedge clk) begin : mon
    res_t r;
    if (clrn && res_valid && res_ready && !flush) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_pop: result tag %0h src %0d with no expected entry", res_tag, res_src);
      end else begin
        r = sb.pop_front();
        chk("res_tag", 32'(res_tag), 32'(r.tag));
        chk("res_src", 32'(res_src), 32'(r.src));
      end
    end
  end

  task automatic cycle();
    @(negedge clk);
    check_and_update();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  // mode 0: drop a granted request; 1: drop and randomly re-request; 2: hold everything
  task automatic next_reqs(input int mode);
    if (mode == 2) return;
    if (g0_last) req0 = 1'b0;
    if (g1_last) req1 = 1'b0;
    if (mode == 1) begin
      if (!req0 && $urandom_range(0, 2) == 0) begin req0 = 1'b1; tag0 = TAGW'($urandom); end
      if (!req1 && $urandom_range(0, 2) == 0) begin req1 = 1'b1; tag1 = TAGW'($urandom); end
    end
  endtask

  task automatic run(input int n, input int mode);
    repeat (n) begin cycle(); next_reqs(mode); end
  endtask

  task automatic wait_pend(input int lim);
    int n = 0;
    while (!m_pend && n < lim) begin cycle(); next_reqs(0); n++; end
    if (!m_pend) begin
      n_tests++; n_fail++;
      $display("FAIL wait_pend: no result within %0d cycles", lim);
    end
  endtask

  task automatic wait_age(input int k, input int lim);
    int n = 0;
    while (!(m_run && cyc - m_gcyc == k) && n < lim) begin cycle(); next_reqs(0); n++; end
    if (!(m_run && cyc - m_gcyc == k)) begin
      n_tests++; n_fail++;
      $display("FAIL wait_age: cnt %0d not reached within %0d cycles", k, lim);
    end
  endtask

  initial begin
    int prev;
    // Reset
    cycle(); cycle();
    clrn = 1'b1;
    cycle();

    // Single op from slot 0
    req0 = 1'b1; tag0 = 5'h0A; res_ready = 1'b1;
    run(LAT + 6, 0);

    // Contention: both held
    req0 = 1'b1; req1 = 1'b1; tag0 = 5'h03; tag1 = 5'h1C;
    run(4 * LAT + 4, 2);
    req0 = 1'b0; req1 = 1'b0;
    run(LAT + 2, 0);

    // Backpressure with a pending slot-1 request
    res_ready = 1'b0; req0 = 1'b1; tag0 = 5'h11;
    wait_pend(2 * LAT);
    req1 = 1'b1; tag1 = 5'h07;
    run(10, 0);
    res_ready = 1'b1;
    run(LAT + 4, 0);

    // Zero-bubble back-to-back
    req0 = 1'b1; tag0 = 5'h19; prev = -1;
    repeat (5 * LAT) begin
      cycle();
      if (s_start) begin
        if (prev >= 0) chk("b2b_period", 32'(s_cyc - prev), LAT);
        prev = s_cyc;
      end
    end
    req0 = 1'b0;
    run(LAT + 2, 0);

    // Flush mid-op, then a new slot-1 request
    req0 = 1'b1; tag0 = 5'h0E;
    wait_age(7, 2 * LAT);
    flush = 1'b1; req1 = 1'b1; tag1 = 5'h15;
    cycle(); next_reqs(0);
    flush = 1'b0;
    run(LAT + 4, 0);

    // Asynchronous reset mid-op, off the clock edge
    req0 = 1'b1; tag0 = 5'h1F;
    wait_age(9, 2 * LAT);
    #1 clrn = 1'b0;
    #1 chk_reset_vals();
    model_reset();
    cycle(); cycle();
    clrn = 1'b1; req0 = 1'b1; req1 = 1'b1; tag0 = 5'h02; tag1 = 5'h12;
    run(LAT + 4, 0);

    // Randomized traffic
    repeat (1500) begin
      res_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 40) == 0);
      cycle();
      next_reqs(1);
    end
    flush = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
